// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO bus initiator: command codes,
// GPIO register map and controller state encoding.
package gpio_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    localparam logic [1:0] GPIO_IN1  = 2'd0;
    localparam logic [1:0] GPIO_IN2  = 2'd1;
    localparam logic [1:0] GPIO_OUT1 = 2'd2;
    localparam logic [1:0] GPIO_OUT2 = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_POLL   = 2'd2,
        S_RESP   = 2'd3
    } state_e;

    // Only the two output registers accept writes.
    function automatic logic addr_writable(input logic [1:0] a);
        return (a == GPIO_OUT1) || (a == GPIO_OUT2);
    endfunction

endpackage

// File: rtl/gpio_master.sv
// Command-driven bus initiator for the GPIO slave port: executes WRITE,
// READ and POLL-until-match commands and returns data plus error status.
module gpio_master
    import gpio_pkg::*;
#(
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [1:0]       req_addr,
    input  logic [31:0]      req_wdata,
    input  logic [31:0]      req_mask,
    input  logic [TMO_W-1:0] req_tmo,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_rdata,
    output logic             resp_err,
    output logic [1:0]       gpio_A,
    output logic             gpio_WE,
    output logic [31:0]      gpio_WD,
    input  logic [31:0]      gpio_RD
);

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      mask_q, mask_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [TMO_W-1:0] cnt_q, cnt_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;
    logic [1:0]       a_q, a_d;
    logic [31:0]      wd_q, wd_d;

    op_e  req_op_e;
    logic req_illegal;
    logic poll_match;
    logic poll_last;

    assign req_op_e    = op_e'(req_op);
    assign req_illegal = (req_op_e == OP_RSVD) ||
                         ((req_op_e == OP_WRITE) && !addr_writable(req_addr));
    assign poll_match  = ((gpio_RD ^ wdata_q) & mask_q) == '0;
    assign poll_last   = (cnt_q == tmo_q);

    // State register with asynchronous reset to IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_illegal)               state_d = S_RESP;
                    else if (req_op_e == OP_POLL)  state_d = S_POLL;
                    else                           state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_POLL:   if (poll_match || poll_last) state_d = S_RESP;
            S_RESP:   if (resp_ready) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // Handshake and write strobe decoded from registered state only.
    always_comb begin
        req_ready  = (state_q == S_IDLE);
        resp_valid = (state_q == S_RESP);
        gpio_WE    = (state_q == S_ACCESS) && (op_q == OP_WRITE);
    end

    // Datapath next values: request latch, poll counter, response capture.
    // The bus address/data registers are loaded at accept so they are
    // already valid during ACCESS/POLL and otherwise keep their last value.
    always_comb begin
        op_d    = op_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        tmo_d   = tmo_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        a_d     = a_q;
        wd_d    = wd_q;
        unique case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d    = req_op_e;
                    wdata_d = req_wdata;
                    mask_d  = req_mask;
                    tmo_d   = req_tmo;
                    cnt_d   = '0;
                    if (req_illegal) begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        a_d = req_addr;
                        if (req_op_e != OP_POLL) wd_d = req_wdata;
                    end
                end
            end
            S_ACCESS: begin
                rdata_d = gpio_RD;
                err_d   = 1'b0;
            end
            S_POLL: begin
                if (poll_match) begin
                    rdata_d = gpio_RD;
                    err_d   = 1'b0;
                end else if (poll_last) begin
                    rdata_d = gpio_RD;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= OP_WRITE;
            wdata_q <= '0;
            mask_q  <= '0;
            tmo_q   <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            a_q     <= '0;
            wd_q    <= '0;
        end else begin
            op_q    <= op_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            a_q     <= a_d;
            wd_q    <= wd_d;
        end
    end

    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;
    assign gpio_A     = a_q;
    assign gpio_WD    = wd_q;

endmodule

// File: tb/tb_gpio_master.sv
// Self-checking bench for gpio_master with a simple GPIO peripheral
// environment and a command-level reference model.
module tb_gpio_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = '0;
    logic [1:0]  req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] req_mask = '0;
    logic [15:0] req_tmo = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [1:0]  gpio_A;
    logic        gpio_WE;
    logic [31:0] gpio_WD;
    logic [31:0] gpio_RD;

    // GPIO peripheral environment
    logic [31:0] gpi1 = '0, gpi2 = '0, gpo1 = '0, gpo2 = '0;
    int          we_cnt = 0;
    logic [1:0]  last_we_a = '0;

    // Reference model state for output registers
    logic [31:0] ref_o1 = '0, ref_o2 = '0;

    int pass_cnt = 0;
    int chk_cnt  = 0;

    gpio_master #(.TMO_W(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .req_tmo(req_tmo),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .gpio_A(gpio_A), .gpio_WE(gpio_WE), .gpio_WD(gpio_WD), .gpio_RD(gpio_RD)
    );

    always #5 clk = ~clk;

    assign gpio_RD = (gpio_A == 2'd0) ? gpi1 :
                     (gpio_A == 2'd1) ? gpi2 :
                     (gpio_A == 2'd2) ? gpo1 : gpo2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gpo1 <= '0;
            gpo2 <= '0;
        end else if (gpio_WE) begin
            if (gpio_A == 2'd2) gpo1 <= gpio_WD;
            if (gpio_A == 2'd3) gpo2 <= gpio_WD;
        end
    end

    always @(posedge clk) begin
        if (gpio_WE) begin
            we_cnt    <= we_cnt + 1;
            last_we_a <= gpio_A;
        end
    end

    function automatic logic [31:0] ref_val(input logic [1:0] a);
        case (a)
            2'd0:    return gpi1;
            2'd1:    return gpi2;
            2'd2:    return ref_o1;
            default: return ref_o2;
        endcase
    endfunction

    // Expected outcome of one command from the command-level rules.
    // For POLL, the addressed input may switch to chg_v from cycle chg_c on
    // (cycle 1 carries sample 0).
    task automatic ref_cmd(input logic [1:0] op, input logic [1:0] a,
                           input logic [31:0] wd, input logic [31:0] mask,
                           input int tmo, input int chg_c, input logic [31:0] chg_v,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int we);
        logic [31:0] v;
        we = 0;
        if (op == 2'd3 || (op == 2'd0 && a < 2)) begin
            lat = 1; rd = 0; er = 1;
        end else if (op == 2'd0) begin
            lat = 2; rd = ref_val(a); er = 0; we = 1;
            if (a == 2'd2) ref_o1 = wd; else ref_o2 = wd;
        end else if (op == 2'd1) begin
            lat = 2; rd = ref_val(a); er = 0;
        end else begin
            lat = tmo + 2; er = 1; rd = 0;
            for (int k = 0; k <= tmo; k++) begin
                v = (chg_c > 0 && k + 1 >= chg_c) ? chg_v : ref_val(a);
                rd = v;
                if ((v & mask) == (wd & mask)) begin
                    lat = k + 2; er = 0;
                    break;
                end
            end
        end
    endtask

    // Drive one command and collect what the DUT did.
    task automatic run_cmd(input logic [1:0] op, input logic [1:0] a,
                           input logic [31:0] wd, input logic [31:0] mask,
                           input logic [15:0] tmo, input int chg_c,
                           input logic [31:0] chg_v, input int hold,
                           output int lat, output logic [31:0] rd, output logic er,
                           output int we, output logic stable, output logic rr_after);
        int base, c, g;
        base = we_cnt;
        lat = -1; rd = 'x; er = 1'bx; stable = 1'b0; rr_after = 1'b0;
        @(negedge clk);
        req_op = op; req_addr = a; req_wdata = wd; req_mask = mask; req_tmo = tmo;
        req_valid = 1'b1;
        g = 0;
        while (req_ready !== 1'b1 && g < 100) begin @(negedge clk); g++; end
        @(posedge clk);
        #1 req_valid = 1'b0;
        c = 0;
        while (c < 300) begin
            @(negedge clk);
            c++;
            if (c == chg_c) begin
                if (a == 2'd0) gpi1 = chg_v; else gpi2 = chg_v;
            end
            if (resp_valid === 1'b1) begin lat = c; break; end
        end
        we = we_cnt - base;
        if (lat < 0) return;
        rd = resp_rdata; er = resp_err; stable = 1'b1;
        repeat (hold) begin
            @(negedge clk);
            if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er ||
                req_ready !== 1'b0) stable = 1'b0;
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        rr_after = req_ready;
        we = we_cnt - base;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_cnt++;
            if (gpio_WE !== 1'b0) $display("FAIL rst_we got %b exp 0", gpio_WE);
            else pass_cnt++;
        end
        rst = 1'b0;
        @(negedge clk);
        chk_cnt++;
        if ({req_ready, resp_valid, resp_err, gpio_WE} !== 4'b1000)
            $display("FAIL rst_ctl got rr=%b rv=%b er=%b we=%b exp 1000",
                     req_ready, resp_valid, resp_err, gpio_WE);
        else pass_cnt++;
        chk_cnt++;
        if ({resp_rdata, gpio_WD, gpio_A} !== 66'd0)
            $display("FAIL rst_data got rd=%h wd=%h a=%0d exp 0", resp_rdata, gpio_WD, gpio_A);
        else pass_cnt++;
        chk_cnt++;
        if (we_cnt !== 0) $display("FAIL rst_we_cnt got %0d exp 0", we_cnt);
        else pass_cnt++;
    endtask

    task automatic test_write_read();
        int lat, elat, we, ewe; logic [31:0] rd, erd; logic er, eer, st, rr;
        ref_cmd(2'd0, 2'd2, 32'hDEADBEEF, 0, 0, 0, 0, elat, erd, eer, ewe);
        run_cmd(2'd0, 2'd2, 32'hDEADBEEF, 0, 0, 0, 0, 0, lat, rd, er, we, st, rr);
        chk_cnt++;
        if (lat !== elat || rd !== erd || er !== eer)
            $display("FAIL wr got lat=%0d rd=%h er=%b exp lat=%0d rd=%h er=%b", lat, rd, er, elat, erd, eer);
        else pass_cnt++;
        chk_cnt++;
        if (we !== 1 || last_we_a !== 2'd2)
            $display("FAIL wr_we got pulses=%0d a=%0d exp 1 a=2", we, last_we_a);
        else pass_cnt++;
        chk_cnt++;
        if (gpo1 !== 32'hDEADBEEF) $display("FAIL wr_reg got %h exp deadbeef", gpo1);
        else pass_cnt++;
        chk_cnt++;
        if (rr !== 1'b1) $display("FAIL wr_ready_after got %b exp 1", rr);
        else pass_cnt++;
        ref_cmd(2'd1, 2'd2, 0, 0, 0, 0, 0, elat, erd, eer, ewe);
        run_cmd(2'd1, 2'd2, 0, 0, 0, 0, 0, 0, lat, rd, er, we, st, rr);
        chk_cnt++;
        if (lat !== 2 || rd !== 32'hDEADBEEF || er !== 1'b0 || we !== 0)
            $display("FAIL rd got lat=%0d rd=%h er=%b we=%0d exp lat=2 rd=deadbeef er=0 we=0", lat, rd, er, we);
        else pass_cnt++;
    endtask

    task automatic test_illegal();
        int lat, elat, we, ewe; logic [31:0] rd, erd, o1, o2; logic er, eer, st, rr;
        logic [1:0] ops [2];
        logic [1:0] ads [2];
        ops[0] = 2'd0; ads[0] = 2'd1;
        ops[1] = 2'd3; ads[1] = 2'd2;
        for (int i = 0; i < 2; i++) begin
            o1 = gpo1; o2 = gpo2;
            ref_cmd(ops[i], ads[i], 32'h1234_5678, 0, 0, 0, 0, elat, erd, eer, ewe);
            run_cmd(ops[i], ads[i], 32'h1234_5678, 0, 0, 0, 0, 0, lat, rd, er, we, st, rr);
            chk_cnt++;
            if (lat !== elat || rd !== erd || er !== eer || we !== 0)
                $display("FAIL illegal%0d got lat=%0d rd=%h er=%b we=%0d exp lat=%0d rd=%h er=%b we=0",
                         i, lat, rd, er, we, elat, erd, eer);
            else pass_cnt++;
            chk_cnt++;
            if (gpo1 !== o1 || gpo2 !== o2)
                $display("FAIL illegal%0d_regs got %h %h exp %h %h", i, gpo1, gpo2, o1, o2);
            else pass_cnt++;
        end
    endtask

    task automatic test_poll();
        int lat, elat, we, ewe; logic [31:0] rd, erd; logic er, eer, st, rr;
        int tmos [3];
        tmos[0] = 10; tmos[1] = 3; tmos[2] = 0;
        gpi1 = 32'h1234_5600;
        ref_cmd(2'd2, 2'd0, 32'h5A, 32'hFF, 10, 5, 32'h1234_565A, elat, erd, eer, ewe);
        run_cmd(2'd2, 2'd0, 32'h5A, 32'hFF, 16'd10, 5, 32'h1234_565A, 0, lat, rd, er, we, st, rr);
        chk_cnt++;
        if (lat !== elat || rd !== erd || er !== eer || we !== 0)
            $display("FAIL poll_match got lat=%0d rd=%h er=%b exp lat=%0d rd=%h er=%b", lat, rd, er, elat, erd, eer);
        else pass_cnt++;
        for (int i = 1; i < 3; i++) begin
            gpi2 = 32'h0000_0F0F;
            ref_cmd(2'd2, 2'd1, 32'hFFFF_FFFF, 32'h0000_FFFF, tmos[i], 0, 0, elat, erd, eer, ewe);
            run_cmd(2'd2, 2'd1, 32'hFFFF_FFFF, 32'h0000_FFFF, 16'(tmos[i]), 0, 0, 0,
                    lat, rd, er, we, st, rr);
            chk_cnt++;
            if (lat !== elat || rd !== erd || er !== eer)
                $display("FAIL poll_tmo%0d got lat=%0d rd=%h er=%b exp lat=%0d rd=%h er=%b",
                         tmos[i], lat, rd, er, elat, erd, eer);
            else pass_cnt++;
        end
    endtask

    task automatic test_hold();
        int lat, elat, we, ewe; logic [31:0] rd, erd; logic er, eer, st, rr;
        ref_cmd(2'd0, 2'd3, 32'hA5A5_0001, 0, 0, 0, 0, elat, erd, eer, ewe);
        run_cmd(2'd0, 2'd3, 32'hA5A5_0001, 0, 0, 0, 0, 5, lat, rd, er, we, st, rr);
        chk_cnt++;
        if (st !== 1'b1 || lat !== elat || rd !== erd || er !== eer)
            $display("FAIL hold got stable=%b lat=%0d rd=%h er=%b exp stable=1 lat=%0d rd=%h er=%b",
                     st, lat, rd, er, elat, erd, eer);
        else pass_cnt++;
        chk_cnt++;
        if (rr !== 1'b1 || gpo2 !== 32'hA5A5_0001)
            $display("FAIL hold_after got rr=%b gpo2=%h exp rr=1 gpo2=a5a50001", rr, gpo2);
        else pass_cnt++;
    endtask

    task automatic test_reset_in_poll();
        logic bad;
        gpi1 = 32'h0;
        @(negedge clk);
        req_op = 2'd2; req_addr = 2'd0; req_wdata = 32'h1; req_mask = 32'h1; req_tmo = 16'd50;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b0)
            $display("FAIL poll_busy got rv=%b rr=%b exp 0 0", resp_valid, req_ready);
        else pass_cnt++;
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || gpio_WE !== 1'b0 || gpio_A !== 2'd0)
            $display("FAIL rst_async got rv=%b rr=%b we=%b a=%0d exp 0 1 0 0",
                     resp_valid, req_ready, gpio_WE, gpio_A);
        else pass_cnt++;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ref_o1 = '0; ref_o2 = '0;
        bad = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        chk_cnt++;
        if (bad !== 1'b0) $display("FAIL rst_idle got bad=%b exp 0", bad);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int lat, elat, we, ewe, tmo; logic [31:0] rd, erd, wd, mk; logic er, eer, st, rr;
        logic [1:0] op, a;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            gpi1 = $urandom; gpi2 = $urandom;
            op = 2'($urandom_range(0, 3));
            a  = 2'($urandom_range(0, 3));
            wd = $urandom;
            mk = $urandom;
            tmo = $urandom_range(0, 5);
            if (op == 2'd2 && $urandom_range(0, 1) == 1) wd = ref_val(a);
            ref_cmd(op, a, wd, mk, tmo, 0, 0, elat, erd, eer, ewe);
            run_cmd(op, a, wd, mk, 16'(tmo), 0, 0, 0, lat, rd, er, we, st, rr);
            chk_cnt++;
            if (lat !== elat || rd !== erd || er !== eer || we !== ewe)
                $display("FAIL rand%0d op=%0d a=%0d got lat=%0d rd=%h er=%b we=%0d exp lat=%0d rd=%h er=%b we=%0d",
                         i, op, a, lat, rd, er, we, elat, erd, eer, ewe);
            else pass_cnt++;
            chk_cnt++;
            if (gpo1 !== ref_o1 || gpo2 !== ref_o2 || rr !== 1'b1)
                $display("FAIL rand%0d_regs got %h %h rr=%b exp %h %h rr=1",
                         i, gpo1, gpo2, rr, ref_o1, ref_o2);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_illegal();
        test_poll();
        test_hold();
        test_reset_in_poll();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
